// File: rtl/target_word_sched.sv
// Round controller: picks each game's secret word from the target-word ROM using an LFSR
// draw with recent-history rejection, then latches the word for the evaluator/display.
module target_word_sched #(
  parameter int         NUM_WORDS  = 100,
  parameter int         IDX_W      = 7,
  parameter int         HIST_DEPTH = 4,
  parameter logic [6:0] LFSR_SEED  = 7'h5A
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_req,
  input  logic             force_en,
  input  logic [IDX_W-1:0] force_idx,
  output logic [IDX_W-1:0] rom_index,
  input  logic [24:0]      rom_word,
  output logic [24:0]      word,
  output logic [IDX_W-1:0] word_idx,
  output logic             word_valid,
  output logic             busy,
  output logic [7:0]       rounds
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DRAW  = 3'd1,
    CHECK = 3'd2,
    LOAD  = 3'd3,
    READY = 3'd4
  } state_t;

  localparam logic [IDX_W-1:0] NUM_WORDS_C = IDX_W'(NUM_WORDS);

  state_t                              state_reg, state_next;
  logic   [6:0]                        lfsr_reg;
  logic   [IDX_W-1:0]                  cand_reg, cand_next;
  logic   [IDX_W-1:0]                  rom_index_reg, rom_index_next;
  logic                                word_valid_reg, word_valid_next;
  logic   [24:0]                       word_reg;
  logic   [IDX_W-1:0]                  word_idx_reg;
  logic   [7:0]                        rounds_reg;
  logic                                load_en;

  logic   [HIST_DEPTH-1:0][IDX_W-1:0]  hist_idx_reg, hist_idx_next;
  logic   [HIST_DEPTH-1:0]             hist_vld_reg, hist_vld_next;
  logic   [HIST_DEPTH-1:0]             hit;

  // History is a shift register: slot 0 takes the newly loaded index, the oldest falls off.
  genvar gi;
  generate
    for (gi = 0; gi < HIST_DEPTH; gi++) begin : g_hist
      assign hit[gi] = hist_vld_reg[gi] && (hist_idx_reg[gi] == cand_reg);
      if (gi == 0) begin : g_head
        assign hist_idx_next[gi] = cand_reg;
        assign hist_vld_next[gi] = 1'b1;
      end else begin : g_tail
        assign hist_idx_next[gi] = hist_idx_reg[gi-1];
        assign hist_vld_next[gi] = hist_vld_reg[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      lfsr_reg       <= LFSR_SEED;
      cand_reg       <= '0;
      rom_index_reg  <= '0;
      word_valid_reg <= 1'b0;
      word_reg       <= '0;
      word_idx_reg   <= '0;
      rounds_reg     <= '0;
      hist_idx_reg   <= '0;
      hist_vld_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      lfsr_reg       <= {lfsr_reg[5:0], lfsr_reg[6] ^ lfsr_reg[5]};
      cand_reg       <= cand_next;
      rom_index_reg  <= rom_index_next;
      word_valid_reg <= word_valid_next;
      if (load_en) begin
        word_reg     <= rom_word;
        word_idx_reg <= cand_reg;
        hist_idx_reg <= hist_idx_next;
        hist_vld_reg <= hist_vld_next;
        if (rounds_reg != 8'hFF) begin
          rounds_reg <= rounds_reg + 8'd1;
        end
      end
    end
  end

  // rom_index is set one edge ahead of LOAD so it is stable for the whole LOAD cycle.
  always_comb begin
    state_next      = state_reg;
    cand_next       = cand_reg;
    rom_index_next  = rom_index_reg;
    word_valid_next = word_valid_reg;
    load_en         = 1'b0;
    case (state_reg)
      IDLE, READY: begin
        if (start_req) begin
          word_valid_next = 1'b0;
          if (force_en && (force_idx < NUM_WORDS_C)) begin
            cand_next      = force_idx;
            rom_index_next = force_idx;
            state_next     = LOAD;
          end else begin
            state_next = DRAW;
          end
        end
      end
      DRAW: begin
        cand_next  = IDX_W'(lfsr_reg - 7'd1);
        state_next = CHECK;
      end
      CHECK: begin
        if ((cand_reg < NUM_WORDS_C) && !(|hit)) begin
          rom_index_next = cand_reg;
          state_next     = LOAD;
        end else begin
          state_next = DRAW;
        end
      end
      LOAD: begin
        load_en         = 1'b1;
        word_valid_next = 1'b1;
        state_next      = READY;
      end
      default: state_next = IDLE;
    endcase
  end

  assign rom_index  = rom_index_reg;
  assign word       = word_reg;
  assign word_idx   = word_idx_reg;
  assign word_valid = word_valid_reg;
  assign rounds     = rounds_reg;
  assign busy       = (state_reg == DRAW) || (state_reg == CHECK) || (state_reg == LOAD);

endmodule

// File: tb/tb_target_word_sched.sv
// Directed bench for target_word_sched with a behavioural ROM and a model of load history.
module tb_target_word_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_req;
  logic        force_en;
  logic [6:0]  force_idx;
  logic [6:0]  rom_index;
  logic [24:0] rom_word;
  logic [24:0] word;
  logic [6:0]  word_idx;
  logic        word_valid;
  logic        busy;
  logic [7:0]  rounds;

  int pass_cnt = 0;
  int total_cnt = 0;
  int rounds_exp = 0;
  int hist_q[$];

  localparam logic [24:0] JOKER = 25'b0100101110010100010010001;
  localparam logic [24:0] MOWER = 25'b0110001110101100010010001;
  localparam logic [24:0] TWEAK = 25'b1001110110001000000001010;

  target_word_sched dut (
    .clk(clk), .rst_n(rst_n), .start_req(start_req), .force_en(force_en),
    .force_idx(force_idx), .rom_index(rom_index), .rom_word(rom_word), .word(word),
    .word_idx(word_idx), .word_valid(word_valid), .busy(busy), .rounds(rounds)
  );

  always #5 clk = ~clk;

  function automatic logic [24:0] rom_f(input logic [6:0] idx);
    case (idx)
      7'd0:    return TWEAK;
      7'd2:    return JOKER;
      7'd99:   return MOWER;
      default: return {idx, ~idx, idx ^ 7'h2B, idx[3:0]};
    endcase
  endfunction

  assign rom_word = rom_f(rom_index);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit in_hist(input int idx);
    foreach (hist_q[i]) if (hist_q[i] == idx) return 1'b1;
    return 1'b0;
  endfunction

  task automatic note_load(input int idx);
    hist_q.push_front(idx);
    if (hist_q.size() > 4) void'(hist_q.pop_back());
    if (rounds_exp < 255) rounds_exp++;
  endtask

  // Start edge, then count edges until word_valid rises.
  task automatic do_round(input logic fe, input logic [6:0] fi,
                          output int lat, output logic busy0, output logic wv0);
    @(negedge clk);
    start_req = 1'b1; force_en = fe; force_idx = fi;
    @(negedge clk);
    start_req = 1'b0; force_en = 1'b0;
    busy0 = busy; wv0 = word_valid;
    lat = 0;
    while (!word_valid && lat < 600) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic rand_round(input string tag);
    int lat; logic b0, w0; bit seen;
    do_round(1'b0, 7'd0, lat, b0, w0);
    seen = in_hist(int'(word_idx));
    chk({tag, "_idx_range"}, 32'(word_idx < 7'd100), 32'd1);
    chk({tag, "_no_repeat"}, 32'(seen), 32'd0);
    chk({tag, "_lat_odd"}, 32'((lat >= 3) && (lat % 2 == 1)), 32'd1);
    chk({tag, "_word"}, 32'(word), 32'(rom_f(word_idx)));
    note_load(int'(word_idx));
    chk({tag, "_rounds"}, 32'(rounds), 32'(rounds_exp));
    $display("round %s idx=%0d lat=%0d rounds=%0d", tag, word_idx, lat, rounds);
  endtask

  task automatic force_round(input string tag, input logic [6:0] fi, input logic [24:0] wexp);
    int lat; logic b0, w0;
    do_round(1'b1, fi, lat, b0, w0);
    chk({tag, "_lat"}, 32'(lat), 32'd1);
    chk({tag, "_idx"}, 32'(word_idx), 32'(fi));
    chk({tag, "_word"}, 32'(word), 32'(wexp));
    note_load(int'(fi));
    chk({tag, "_rounds"}, 32'(rounds), 32'(rounds_exp));
    $display("force %s idx=%0d word=%07h rounds=%0d", tag, word_idx, word, rounds);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_word"}, 32'(word), 32'd0);
    chk({tag, "_word_idx"}, 32'(word_idx), 32'd0);
    chk({tag, "_rom_index"}, 32'(rom_index), 32'd0);
    chk({tag, "_word_valid"}, 32'(word_valid), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_rounds"}, 32'(rounds), 32'd0);
  endtask

  initial begin
    int lat, n;
    logic b0, w0;

    // 1: reset and idle
    rst_n = 1'b0; start_req = 1'b0; force_en = 1'b0; force_idx = 7'd0;
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("idle_valid", 32'(word_valid), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    $display("reset and idle done");

    // 2: forced loads
    force_round("f2", 7'd2, JOKER);
    force_round("f99", 7'd99, MOWER);
    force_round("f0", 7'd0, TWEAK);

    // 3: out-of-range force falls back to the random path
    do_round(1'b1, 7'd100, lat, b0, w0);
    chk("bad_busy", 32'(b0), 32'd1);
    chk("bad_valid_fall", 32'(w0), 32'd0);
    chk("bad_idx_range", 32'(word_idx < 7'd100), 32'd1);
    chk("bad_lat_odd", 32'((lat >= 3) && (lat % 2 == 1)), 32'd1);
    chk("bad_word", 32'(word), 32'(rom_f(word_idx)));
    note_load(int'(word_idx));
    $display("bad force idx=%0d lat=%0d", word_idx, lat);

    // 4: back-to-back random rounds
    for (int i = 0; i < 50; i++) rand_round($sformatf("r%0d", i));

    // 5a: start_req while busy is ignored
    @(negedge clk);
    start_req = 1'b1;
    @(negedge clk);
    chk("ign_busy0", 32'(busy), 32'd1);
    @(negedge clk);
    chk("ign_busy1", 32'(busy), 32'd1);
    @(negedge clk);
    start_req = 1'b0;
    n = 0;
    while (!word_valid && n < 600) begin
      @(negedge clk);
      n++;
    end
    note_load(int'(word_idx));
    repeat (6) @(negedge clk);
    chk("ign_valid", 32'(word_valid), 32'd1);
    chk("ign_busy_end", 32'(busy), 32'd0);
    chk("ign_rounds", 32'(rounds), 32'(rounds_exp));
    $display("busy ignore idx=%0d rounds=%0d", word_idx, rounds);

    // 6: forced index bypasses history, then random draws avoid it
    force_round("f7a", 7'd7, rom_f(7'd7));
    force_round("f7b", 7'd7, rom_f(7'd7));
    for (int i = 0; i < 4; i++) begin
      rand_round($sformatf("p%0d", i));
      chk($sformatf("p%0d_not7", i), 32'(word_idx != 7'd7), 32'd1);
    end

    // 4b: rounds saturation
    while (rounds_exp < 255) begin
      do_round(1'b1, 7'(rounds_exp % 100), lat, b0, w0);
      note_load(rounds_exp % 100);
    end
    chk("sat_255", 32'(rounds), 32'd255);
    force_round("sat_more", 7'd2, JOKER);
    force_round("sat_more2", 7'd99, MOWER);
    chk("sat_hold", 32'(rounds), 32'd255);

    // 5b: reset during CHECK aborts and clears everything
    @(negedge clk);
    start_req = 1'b1;
    @(negedge clk);
    start_req = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("abort");
    @(negedge clk);
    rst_n = 1'b1;
    hist_q.delete();
    rounds_exp = 0;
    repeat (3) @(negedge clk);
    chk("abort_idle", 32'(busy), 32'd0);
    force_round("post_rst", 7'd2, JOKER);
    rand_round("post_rand");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
